// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two ALU requesters, the consumer and the shared-ALU arbiter.
// The master side drives requests and consumes results; the slave side is the arbiter.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [5:0]  req0_fn;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [5:0]  req1_fn;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_y;
    logic        rsp_id;
    logic        rsp_err;

    modport master (
        output req0_valid, req0_a, req0_b, req0_fn,
        output req1_valid, req1_a, req1_b, req1_fn,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_y, rsp_id, rsp_err
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_fn,
        input  req1_valid, req1_a, req1_b, req1_fn,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_y, rsp_id, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// One combinational ALU shared by two requesters through a round-robin IDLE/EXEC/RESP arbiter.
// Results are registered and held until the consumer takes them.
module alu (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [5:0]  FN,
    output logic [31:0] Y
);
    always_comb begin
        Y = '0;
        case (FN)
            6'b000011: Y = {31'b0, A == B};
            6'b000101: Y = {31'b0, $signed(A) <  $signed(B)};
            6'b000111: Y = {31'b0, $signed(A) <= $signed(B)};
            6'b010000: Y = A + B;
            6'b010001: Y = A - B;
            6'b110000: Y = A << B[4:0];
            6'b110001: Y = A >> B[4:0];
            6'b110011: Y = 32'($signed(A) >>> B[4:0]);
            6'b101010: Y = A;
            6'b101000: Y = A & B;
            6'b101110: Y = A | B;
            6'b100110: Y = A ^ B;
            default:   Y = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter logic RST_PRI = 1'b0
) (
    input logic          clk,
    input logic          n_rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [5:0]  op_fn_q, op_fn_d;
    logic        op_id_q, op_id_d;
    logic [31:0] rsp_y_q, rsp_y_d;
    logic        rsp_id_q, rsp_id_d;
    logic        rsp_err_q, rsp_err_d;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic        grant_any;
    logic        grant_id;
    logic        transfer;
    logic        idle;
    logic        rsp_valid;
    logic        fn_illegal;
    logic [31:0] alu_y;

    assign req_valid = {bus.req1_valid, bus.req0_valid};

    // A lone requester wins outright; contention is settled by the pointer.
    always_comb begin
        grant_any = |req_valid;
        grant_id  = ptr_q;
        if (req_valid == 2'b01) begin
            grant_id = 1'b0;
        end else if (req_valid == 2'b10) begin
            grant_id = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = idle && n_rst && grant_any && (grant_id == 1'(gi));
        end
    endgenerate

    assign transfer = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (transfer) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idle      = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
    end

    always_comb begin
        fn_illegal = 1'b1;
        case (op_fn_q)
            6'b000011, 6'b000101, 6'b000111,
            6'b010000, 6'b010001,
            6'b110000, 6'b110001, 6'b110011,
            6'b101010, 6'b101000, 6'b101110, 6'b100110: fn_illegal = 1'b0;
            default:                                    fn_illegal = 1'b1;
        endcase
    end

    // The ALU only ever sees the captured operands, never the live request buses.
    alu u_alu (
        .A  (op_a_q),
        .B  (op_b_q),
        .FN (op_fn_q),
        .Y  (alu_y)
    );

    always_comb begin
        ptr_d     = ptr_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_fn_d   = op_fn_q;
        op_id_d   = op_id_q;
        rsp_y_d   = rsp_y_q;
        rsp_id_d  = rsp_id_q;
        rsp_err_d = rsp_err_q;
        if (transfer) begin
            op_a_d  = grant_id ? bus.req1_a  : bus.req0_a;
            op_b_d  = grant_id ? bus.req1_b  : bus.req0_b;
            op_fn_d = grant_id ? bus.req1_fn : bus.req0_fn;
            op_id_d = grant_id;
            ptr_d   = ~grant_id;
        end
        if (state_q == EXEC) begin
            rsp_y_d   = fn_illegal ? 32'h0 : alu_y;
            rsp_id_d  = op_id_q;
            rsp_err_d = fn_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            ptr_q     <= RST_PRI;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_fn_q   <= '0;
            op_id_q   <= 1'b0;
            rsp_y_q   <= '0;
            rsp_id_q  <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_fn_q   <= op_fn_d;
            op_id_q   <= op_id_d;
            rsp_y_q   <= rsp_y_d;
            rsp_id_q  <= rsp_id_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_y      = rsp_y_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed stimulus pushes expected responses,
// an independent monitor pops and compares them as the arbiter presents results.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    alu_arbiter_if bus ();

    alu_arbiter #(.RST_PRI(1'b0)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        id;
        logic [31:0] y;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  fn;
        logic [31:0] y;
        logic        err;
    } vec_t;

    localparam int NV = 13;
    localparam vec_t VECS [NV] = '{
        '{1'b0, 32'h00000001, 32'hFFFFFF9C, 6'b010000, 32'hFFFFFF9D, 1'b0},
        '{1'b1, 32'h00000005, 32'h00000007, 6'b010001, 32'hFFFFFFFE, 1'b0},
        '{1'b0, 32'h00000005, 32'h00000007, 6'b111111, 32'h00000000, 1'b1},
        '{1'b0, 32'h00000005, 32'h00000007, 6'b010001, 32'hFFFFFFFE, 1'b0},
        '{1'b1, 32'hF0F000FF, 32'h0FF00F0F, 6'b101000, 32'h00F0000F, 1'b0},
        '{1'b0, 32'h12340000, 32'h00005678, 6'b101110, 32'h12345678, 1'b0},
        '{1'b1, 32'hAAAA5555, 32'hFFFF0000, 6'b100110, 32'h55555555, 1'b0},
        '{1'b0, 32'h00000001, 32'h0000001F, 6'b110000, 32'h80000000, 1'b0},
        '{1'b1, 32'h80000000, 32'h00000004, 6'b110001, 32'h08000000, 1'b0},
        '{1'b0, 32'h00000007, 32'h00000007, 6'b000011, 32'h00000001, 1'b0},
        '{1'b1, 32'h00000005, 32'hFFFFFFFD, 6'b000101, 32'h00000000, 1'b0},
        '{1'b0, 32'h7FFFFFFF, 32'h00000001, 6'b010000, 32'h80000000, 1'b0},
        '{1'b1, 32'h00000003, 32'h00000004, 6'b000000, 32'h00000000, 1'b1}
    };

    exp_t exp_q [$];
    int   acc_q [$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic push_exp(input logic id, input logic [31:0] y, input logic err);
        exp_q.push_back('{id, y, err});
    endtask

    // Present one operation and hold it until accepted; called at posedge+1.
    task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] fn, input bit track);
        bit acc = 1'b0;
        if (id) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_fn = fn; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_fn = fn; bus.req0_valid = 1'b1;
        end
        for (int i = 0; i < 60 && !acc; i++) begin
            @(negedge clk);
            if ((id && bus.req1_ready) || (!id && bus.req0_ready)) begin
                acc = 1'b1;
                if (track) acc_q.push_back(cyc);
                $display("req id=%0d fn=%b a=%h b=%h accepted cycle=%0d", id, fn, a, b, cyc);
            end
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout id=%0d got=no_ready want=ready", id);
        end
        @(posedge clk);
        #1;
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (exp_q.size() != 0 || bus.rsp_valid); i++) @(negedge clk);
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_rst = 1'b1;
    endtask

    // Monitor: compares each new response, then checks it stays stable while stalled.
    bit   hold = 1'b0;
    exp_t held;
    always @(negedge clk) begin
        exp_t e;
        if (!n_rst) begin
            hold = 1'b0;
        end else begin
            chk("ready_exclusive", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            if (bus.rsp_valid) begin
                if (!hold) begin
                    $display("rsp id=%0d y=%h err=%0d cycle=%0d", bus.rsp_id, bus.rsp_y, bus.rsp_err, cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_rsp got id=%0d y=%h want=none", bus.rsp_id, bus.rsp_y);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                        chk("rsp_y", bus.rsp_y, e.y);
                        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                        if (acc_q.size() != 0) chk("latency", 32'(cyc - acc_q.pop_front()), 32'd2);
                    end
                    held = '{bus.rsp_id, bus.rsp_y, bus.rsp_err};
                end else begin
                    chk("hold_id", 32'(bus.rsp_id), 32'(held.id));
                    chk("hold_y", bus.rsp_y, held.y);
                    chk("hold_err", 32'(bus.rsp_err), 32'(held.err));
                end
                if (bus.req0_valid || bus.req1_valid)
                    chk("ready_in_resp", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
                hold = !bus.rsp_ready;
            end else begin
                hold = 1'b0;
            end
        end
    end

    initial begin
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_fn = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_fn = '0;
        bus.rsp_ready  = 1'b1;

        // Reset state, with both requesters knocking.
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("ready_in_reset", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        end
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_y", bus.rsp_y, 32'd0);
        chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        n_rst = 1'b1;

        // Single-requester operations across the function set.
        for (int i = 0; i < NV; i++) begin
            push_exp(VECS[i].id, VECS[i].y, VECS[i].err);
            issue(VECS[i].id, VECS[i].a, VECS[i].b, VECS[i].fn, 1'b1);
        end
        drain();

        // Continuous contention alternates starting from the reset pointer.
        do_reset();
        push_exp(1'b0, 32'hFFFFFFFE, 1'b0);
        push_exp(1'b1, 32'h00000001, 1'b0);
        push_exp(1'b0, 32'hFFFFFFFE, 1'b0);
        push_exp(1'b1, 32'h00000001, 1'b0);
        fork
            begin
                issue(1'b0, 32'hFFFFFFF8, 32'd2, 6'b110011, 1'b1);
                issue(1'b0, 32'hFFFFFFF8, 32'd2, 6'b110011, 1'b1);
            end
            begin
                issue(1'b1, 32'hFFFFFFF8, 32'd95999, 6'b000111, 1'b1);
                issue(1'b1, 32'hFFFFFFF8, 32'd95999, 6'b000111, 1'b1);
            end
        join
        drain();

        // Reset while in EXEC drops the operation and restores the pointer.
        issue(1'b0, 32'd1, 32'd2, 6'b010000, 1'b0);
        n_rst = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_rsp_after_reset", 32'(bus.rsp_valid), 32'd0);
        end
        chk("post_reset_rsp_y", bus.rsp_y, 32'd0);
        chk("post_reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("post_reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        @(posedge clk); #1;
        push_exp(1'b0, 32'd5, 1'b0);
        push_exp(1'b1, 32'd6, 1'b0);
        fork
            issue(1'b0, 32'd2, 32'd3, 6'b010000, 1'b1);
            issue(1'b1, 32'd10, 32'd4, 6'b010001, 1'b1);
        join
        drain();

        // Consumer stall: response held, nothing accepted, IDLE one cycle after release.
        bus.rsp_ready = 1'b0;
        push_exp(1'b1, 32'hFFFFFFF8, 1'b0);
        issue(1'b1, 32'hFFFFFFF8, 32'd590, 6'b101010, 1'b1);
        push_exp(1'b0, 32'd2, 1'b0);
        fork
            issue(1'b0, 32'd1, 32'd1, 6'b010000, 1'b1);
        join_none
        repeat (5) begin
            @(negedge clk);
            chk("stall_req0_ready", 32'(bus.req0_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        @(negedge clk);
        chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("idle_req0_ready", 32'(bus.req0_ready), 32'd1);
        wait fork;
        drain();

        // A one-cycle pulse during RESP is ignored and leaves the pointer alone.
        do_reset();
        bus.rsp_ready = 1'b0;
        push_exp(1'b0, 32'd9, 1'b0);
        issue(1'b0, 32'd4, 32'd5, 6'b010000, 1'b1);
        @(posedge clk); #1;
        bus.req0_a = 32'd100; bus.req0_b = 32'd1; bus.req0_fn = 6'b010000;
        bus.req0_valid = 1'b1;
        @(negedge clk);
        chk("pulse_req0_ready", 32'(bus.req0_ready), 32'd0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        drain();
        push_exp(1'b1, 32'h00000003, 1'b0);
        push_exp(1'b0, 32'h00000007, 1'b0);
        fork
            issue(1'b0, 32'd3, 32'd4, 6'b010000, 1'b1);
            issue(1'b1, 32'd1, 32'd2, 6'b101110, 1'b1);
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RST_PRI, default 0, requester index holding priority after reset (0 or 1).
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 n_rst  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester n's operation this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32  operands A and B of requester n.
REQ-007 req0_fn / req1_fn  input  6  ALU function code of requester n.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer takes result this cycle.
REQ-010 rsp_y  output  32  ALU result.
REQ-011 rsp_id  output  1  index of the requester that issued the result.
REQ-012 rsp_err  output  1  issued function code was illegal.

Function
REQ-013 The block SHALL instantiate exactly one alu (ports A, B, FN, Y) and share it between two requesters.
REQ-014 FSM states SHALL be IDLE, EXEC, RESP; IDLE->EXEC on an accepted request, EXEC->RESP unconditionally, RESP->IDLE on rsp_valid&rsp_ready; all other cases hold state.
REQ-015 reqN_ready SHALL be asserted only in IDLE, only for the granted requester, and never for both in the same cycle.
REQ-016 Grant: only one valid -> that one; both valid -> requester equal to priority pointer; none valid -> no grant.
REQ-017 On every accepted transfer (reqN_valid&reqN_ready), the priority pointer SHALL move to the other requester; otherwise it holds.
REQ-018 On transfer, A, B, FN and id SHALL be captured into operand registers; the alu SHALL be driven only from these registers.
REQ-019 In EXEC, alu Y SHALL be registered into rsp_y; rsp_err SHALL be registered as 1 when FN is not one of 000011, 000101, 000111, 010000, 010001, 110000, 110001, 110011, 101010, 101000, 101110, 100110.
REQ-020 When rsp_err is 1, rsp_y SHALL be 32'h00000000 regardless of alu output.
REQ-021 Latency: transfer at edge t -> rsp_valid high after edge t+2; minimum issue interval 3 cycles.
REQ-022 rsp_valid SHALL be 1 exactly in RESP; rsp_y, rsp_id and rsp_err SHALL stay stable while rsp_valid&!rsp_ready.
REQ-023 No request SHALL be accepted in EXEC or RESP, including the cycle in which rsp_ready is high (accepting resumes in IDLE).
REQ-024 Requesters hold valid and operands until ready; a requester deasserting valid before ready is not served and leaves the pointer unchanged.
REQ-025 Operand and result widths SHALL be 32 bits with no truncation or extension by the arbiter; overflow behaviour is the alu's.

Reset
REQ-026 With n_rst=0 at a rising edge: state=IDLE, pointer=RST_PRI, rsp_valid=0, rsp_y=0, rsp_id=0, rsp_err=0, operand registers=0.
REQ-027 Reset in EXEC or RESP SHALL discard the in-flight operation; no response is emitted afterwards.
REQ-028 reqN_ready SHALL be 0 during any cycle in which n_rst=0.

Verification
REQ-029 req0 ADD, A=1, B=-100, rsp_ready=1 -> rsp_valid two cycles after transfer, rsp_y=32'hFFFFFF9D, rsp_id=0, rsp_err=0.
REQ-030 Both valid continuously, req0 SRA A=-8 B=2, req1 CMPLE A=-8 B=95999, RST_PRI=0 -> responses alternate id 0 (32'hFFFFFFFE), id 1 (32'h00000001), id 0, ...
REQ-031 req1 AFN A=-8 B=590, rsp_ready low 4 cycles -> rsp_valid/rsp_y/rsp_id held stable, both reqN_ready 0 throughout, IDLE reentered one cycle after rsp_ready rises.
REQ-032 req0 FN=6'b111111 A=5 B=7 -> rsp_err=1, rsp_y=0, rsp_id=0; next request processed normally.
REQ-033 n_rst=0 for one cycle while in EXEC -> no rsp_valid afterward, outputs at reset values, pointer=RST_PRI, next request accepted from IDLE.
REQ-034 req0_valid pulsed 1 cycle while FSM in RESP -> not accepted, no response for it, pointer unchanged.
